pac_motion_ctrl: RTL and testbench

- Pac-Man movement engine. Sits directly upstream of the pac sprite controller and supplies it with Pac-Man's pixel position, facing direction and mouth animation frame.
- Once per video frame, on the rising edge of VGA_VS, it applies the buffered keyboard turn request and moves Pac-Man by 1 pixel.
- Before turning or advancing, it queries a maze wall-tile ROM through a req/valid handshake.

---
 rtl/pac_motion_ctrl.sv | 158 +++++++++++++++
 tb/tb_pac_motion_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pac_motion_ctrl.sv
// pac_motion_ctrl: Pac-Man movement engine. Moves one pixel per frame tick, buffers turns
// and checks walls through a req/valid tile-ROM handshake.
module pac_motion_ctrl #(
    parameter int MAZE_W_TILES = 28,
    parameter int MAZE_H_TILES = 31,
    parameter int START_X      = 112,
    parameter int START_Y      = 184,
    parameter int ANIM_DIV     = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic       wall_req,
    output logic [9:0] wall_addr,
    input  logic       wall_valid,
    input  logic       wall_is_wall,
    output logic [9:0] pac_x,
    output logic [9:0] pac_y,
    output logic [1:0] pac_dir,
    output logic       moving,
    output logic [1:0] anim_frame,
    output logic       tick_overrun
);
    localparam logic [9:0] X_MAX  = 10'(MAZE_W_TILES * 8 - 1);
    localparam logic [6:0] TX_MAX = 7'(MAZE_W_TILES - 1);
    localparam logic [6:0] TY_MAX = 7'(MAZE_H_TILES - 1);

    typedef enum logic [2:0] {S_IDLE, S_CHK_TURN, S_WAIT_TURN, S_CHK_FWD, S_WAIT_FWD, S_MOVE} state_t;

    state_t      r_state;
    logic [2:0]  r_fs;
    logic [9:0]  r_x, r_y, r_addr;
    logic [1:0]  r_dir, r_pend_dir, r_turn_dir, r_anim;
    logic        r_pend_v, r_moving, r_overrun, r_req;
    logic [7:0]  r_anim_cnt;
    logic        w_tick, w_aligned, w_key_v;
    logic [1:0]  w_key_dir;
    logic [10:0] w_nb_turn, w_nb_fwd;

    // Returns {lookup_allowed, tile_addr} for the tile next to (x,y) in direction d.
    function automatic logic [10:0] nbr(input logic [1:0] d, input logic [9:0] x, input logic [9:0] y);
        logic [6:0] tx, ty;
        logic       ok;
        tx = (d == 2'd0) ? ((x[9:3] == TX_MAX) ? 7'd0 : x[9:3] + 7'd1) :
             (d == 2'd2) ? ((x[9:3] == 7'd0) ? TX_MAX : x[9:3] - 7'd1) : x[9:3];
        ty = (d == 2'd1) ? y[9:3] + 7'd1 : (d == 2'd3) ? y[9:3] - 7'd1 : y[9:3];
        ok = !((d == 2'd3) && (y[9:3] == 7'd0)) && !((d == 2'd1) && (y[9:3] >= TY_MAX));
        return {ok, 10'(ty * MAZE_W_TILES + tx)};
    endfunction

    always_comb begin
        w_tick    = r_fs[1] & ~r_fs[2];
        w_aligned = (r_x[2:0] == 3'd0) && (r_y[2:0] == 3'd0);
        w_key_v   = (keycode == 8'h07) || (keycode == 8'h16) || (keycode == 8'h04) || (keycode == 8'h1A);
        w_key_dir = (keycode == 8'h07) ? 2'd0 : (keycode == 8'h16) ? 2'd1 : (keycode == 8'h04) ? 2'd2 : 2'd3;
        w_nb_turn = nbr(r_pend_dir, r_x, r_y);
        w_nb_fwd  = nbr(r_dir, r_x, r_y);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_IDLE;
            r_fs       <= 3'd0;
            r_x        <= 10'(START_X);
            r_y        <= 10'(START_Y);
            r_dir      <= 2'd2;
            r_pend_dir <= 2'd2;
            r_turn_dir <= 2'd2;
            r_pend_v   <= 1'b0;
            r_moving   <= 1'b0;
            r_overrun  <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= 10'd0;
            r_anim     <= 2'd0;
            r_anim_cnt <= 8'd0;
        end else begin
            r_fs <= {r_fs[1:0], frame_clk};
            if (w_tick && r_state != S_IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: if (w_tick) begin
                    if (r_pend_v && r_pend_dir == (r_dir ^ 2'd2)) begin
                        r_dir    <= r_pend_dir;
                        r_pend_v <= 1'b0;
                        r_state  <= S_MOVE;
                    end else if (!w_aligned)
                        r_state <= S_MOVE;
                    else if (r_pend_v && r_pend_dir != r_dir)
                        r_state <= S_CHK_TURN;
                    else begin
                        if (r_pend_dir == r_dir)
                            r_pend_v <= 1'b0;
                        r_state <= S_CHK_FWD;
                    end
                end
                // Out-of-maze rows count as walls without touching the ROM.
                S_CHK_TURN: if (w_nb_turn[10]) begin
                    r_req      <= 1'b1;
                    r_addr     <= w_nb_turn[9:0];
                    r_turn_dir <= r_pend_dir;
                    r_state    <= S_WAIT_TURN;
                end else
                    r_state <= S_CHK_FWD;
                S_WAIT_TURN: if (wall_valid) begin
                    r_req <= 1'b0;
                    if (!wall_is_wall) begin
                        r_dir    <= r_turn_dir;
                        r_pend_v <= 1'b0;
                        r_state  <= S_MOVE;
                    end else
                        r_state <= S_CHK_FWD;
                end
                S_CHK_FWD: if (w_nb_fwd[10]) begin
                    r_req   <= 1'b1;
                    r_addr  <= w_nb_fwd[9:0];
                    r_state <= S_WAIT_FWD;
                end else begin
                    r_moving <= 1'b0;
                    r_state  <= S_IDLE;
                end
                S_WAIT_FWD: if (wall_valid) begin
                    r_req <= 1'b0;
                    if (wall_is_wall)
                        r_moving <= 1'b0;
                    r_state <= wall_is_wall ? S_IDLE : S_MOVE;
                end
                S_MOVE: begin
                    r_x <= (r_dir == 2'd0) ? ((r_x == X_MAX) ? 10'd0 : r_x + 10'd1) :
                           (r_dir == 2'd2) ? ((r_x == 10'd0) ? X_MAX : r_x - 10'd1) : r_x;
                    r_y <= (r_dir == 2'd1) ? r_y + 10'd1 : (r_dir == 2'd3) ? r_y - 10'd1 : r_y;
                    r_moving <= 1'b1;
                    if (r_anim_cnt == 8'(ANIM_DIV - 1)) begin
                        r_anim_cnt <= 8'd0;
                        r_anim     <= r_anim + 2'd1;
                    end else
                        r_anim_cnt <= r_anim_cnt + 8'd1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // A fresh key overrides any clear made above in the same cycle.
            if (w_key_v) begin
                r_pend_dir <= w_key_dir;
                r_pend_v   <= 1'b1;
            end
        end
    end

    assign wall_req     = r_req;
    assign wall_addr    = r_addr;
    assign pac_x        = r_x;
    assign pac_y        = r_y;
    assign pac_dir      = r_dir;
    assign moving       = r_moving;
    assign anim_frame   = r_anim;
    assign tick_overrun = r_overrun;
endmodule

// File: tb/tb_pac_motion_ctrl.sv
// tb_pac_motion_ctrl: directed scenarios for pac_motion_ctrl with a behavioural wall ROM
// (fixed latency, per-tile wall map, optional stall).
module tb_pac_motion_ctrl;
    logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
    logic [7:0] keycode = 8'd0;
    logic       wall_req, wall_valid = 1'b0, wall_is_wall = 1'b0;
    logic [9:0] wall_addr, pac_x, pac_y;
    logic [1:0] pac_dir, anim_frame;
    logic       moving, tick_overrun;

    logic       blk [0:1023];
    logic       rom_stall = 1'b0;
    int         rom_cnt = 0, req_cnt = 0;
    logic       req_q = 1'b0;
    logic [9:0] rom_last = 10'd0;
    int         checks = 0, errors = 0;
    int         n0;

    pac_motion_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
        .wall_req(wall_req), .wall_addr(wall_addr), .wall_valid(wall_valid),
        .wall_is_wall(wall_is_wall), .pac_x(pac_x), .pac_y(pac_y), .pac_dir(pac_dir),
        .moving(moving), .anim_frame(anim_frame), .tick_overrun(tick_overrun)
    );

    always #10 Clk = ~Clk;

    // Wall ROM: answers 3 cycles after the request rises unless stalled.
    always @(posedge Clk) begin
        wall_valid <= 1'b0;
        req_q      <= wall_req;
        if (wall_req && !req_q)
            req_cnt <= req_cnt + 1;
        if (wall_req && !wall_valid && !rom_stall) begin
            if (rom_cnt == 2) begin
                wall_valid   <= 1'b1;
                wall_is_wall <= blk[wall_addr];
                rom_last     <= wall_addr;
                rom_cnt      <= 0;
            end else
                rom_cnt <= rom_cnt + 1;
        end else if (!wall_req)
            rom_cnt <= 0;
    end

    task automatic clear_blk();
        for (int i = 0; i < 1024; i++) blk[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk) Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            repeat (20) @(posedge Clk);
            frame_clk = 1'b0;
            repeat (20) @(posedge Clk);
        end
        @(negedge Clk);
    endtask

    task automatic press(input logic [7:0] k);
        @(negedge Clk) keycode = k;
        repeat (2) @(negedge Clk);
        keycode = 8'd0;
    endtask

    task automatic test_reset();
        clear_blk();
        do_reset();
        checks += 6;
        if (pac_x !== 10'd112) begin errors++; $display("FAIL reset_x got %0d want 112", pac_x); end
        if (pac_y !== 10'd184) begin errors++; $display("FAIL reset_y got %0d want 184", pac_y); end
        if (pac_dir !== 2'd2) begin errors++; $display("FAIL reset_dir got %0d want 2", pac_dir); end
        if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving got %b want 0", moving); end
        if (wall_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", wall_req); end
        if (tick_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", tick_overrun); end
    endtask

    task automatic test_corridor();
        n0 = req_cnt;
        tick(8);
        checks += 6;
        if (pac_x !== 10'd104) begin errors++; $display("FAIL corr_x got %0d want 104", pac_x); end
        if (pac_y !== 10'd184) begin errors++; $display("FAIL corr_y got %0d want 184", pac_y); end
        if (req_cnt - n0 !== 1) begin errors++; $display("FAIL corr_lookups got %0d want 1", req_cnt - n0); end
        if (rom_last !== 10'd657) begin errors++; $display("FAIL corr_addr got %0d want 657", rom_last); end
        if (anim_frame !== 2'd2) begin errors++; $display("FAIL corr_anim got %0d want 2", anim_frame); end
        if (moving !== 1'b1) begin errors++; $display("FAIL corr_moving got %b want 1", moving); end
    endtask

    task automatic test_buffered_turn();
        clear_blk();
        blk[629] = 1'b1;
        blk[630] = 1'b1;
        do_reset();
        tick(2);
        press(8'h1A);
        tick(14);
        checks += 4;
        if (pac_x !== 10'd96) begin errors++; $display("FAIL turn_x got %0d want 96", pac_x); end
        if (pac_y !== 10'd184) begin errors++; $display("FAIL turn_y0 got %0d want 184", pac_y); end
        if (pac_dir !== 2'd2) begin errors++; $display("FAIL turn_dir0 got %0d want 2", pac_dir); end
        if (rom_last !== 10'd656) begin errors++; $display("FAIL turn_addr0 got %0d want 656", rom_last); end
        tick(1);
        checks += 4;
        if (pac_dir !== 2'd3) begin errors++; $display("FAIL turn_dir got %0d want 3", pac_dir); end
        if (pac_y !== 10'd183) begin errors++; $display("FAIL turn_y1 got %0d want 183", pac_y); end
        if (pac_x !== 10'd96) begin errors++; $display("FAIL turn_x1 got %0d want 96", pac_x); end
        if (rom_last !== 10'd628) begin errors++; $display("FAIL turn_addr1 got %0d want 628", rom_last); end
        tick(1);
        checks++;
        if (pac_y !== 10'd182) begin errors++; $display("FAIL turn_y2 got %0d want 182", pac_y); end
    endtask

    task automatic test_reverse();
        clear_blk();
        do_reset();
        tick(3);
        press(8'h07);
        n0 = req_cnt;
        tick(1);
        checks += 3;
        if (pac_dir !== 2'd0) begin errors++; $display("FAIL rev_dir got %0d want 0", pac_dir); end
        if (pac_x !== 10'd110) begin errors++; $display("FAIL rev_x got %0d want 110", pac_x); end
        if (req_cnt !== n0) begin errors++; $display("FAIL rev_lookups got %0d want %0d", req_cnt, n0); end
    endtask

    task automatic test_wall_stop();
        clear_blk();
        blk[656] = 1'b1;
        do_reset();
        tick(9);
        checks += 3;
        if (rom_last !== 10'd656) begin errors++; $display("FAIL wall_addr got %0d want 656", rom_last); end
        if (moving !== 1'b0) begin errors++; $display("FAIL wall_moving got %b want 0", moving); end
        if (pac_x !== 10'd104) begin errors++; $display("FAIL wall_x got %0d want 104", pac_x); end
        tick(2);
        checks += 3;
        if (pac_x !== 10'd104) begin errors++; $display("FAIL wall_hold_x got %0d want 104", pac_x); end
        if (moving !== 1'b0) begin errors++; $display("FAIL wall_hold_mv got %b want 0", moving); end
        if (anim_frame !== 2'd2) begin errors++; $display("FAIL wall_anim got %0d want 2", anim_frame); end
    endtask

    task automatic test_tunnel_overrun();
        clear_blk();
        do_reset();
        tick(112);
        checks++;
        if (pac_x !== 10'd0) begin errors++; $display("FAIL tun_x0 got %0d want 0", pac_x); end
        tick(1);
        checks += 2;
        if (pac_x !== 10'd223) begin errors++; $display("FAIL tun_wrap got %0d want 223", pac_x); end
        if (rom_last !== 10'd671) begin errors++; $display("FAIL tun_addr got %0d want 671", rom_last); end
        tick(7);
        rom_stall = 1'b1;
        tick(1);
        checks += 3;
        if (wall_req !== 1'b1) begin errors++; $display("FAIL ovr_req got %b want 1", wall_req); end
        if (tick_overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre got %b want 0", tick_overrun); end
        if (pac_x !== 10'd216) begin errors++; $display("FAIL ovr_x0 got %0d want 216", pac_x); end
        tick(1);
        checks += 2;
        if (tick_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", tick_overrun); end
        if (pac_x !== 10'd216) begin errors++; $display("FAIL ovr_x1 got %0d want 216", pac_x); end
        rom_stall = 1'b0;
        repeat (10) @(negedge Clk);
        checks += 3;
        if (pac_x !== 10'd215) begin errors++; $display("FAIL ovr_x2 got %0d want 215", pac_x); end
        if (tick_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", tick_overrun); end
        if (wall_req !== 1'b0) begin errors++; $display("FAIL ovr_req_drop got %b want 0", wall_req); end
    endtask

    initial begin
        test_reset();
        test_corridor();
        test_buffered_turn();
        test_reverse();
        test_wall_stop();
        test_tunnel_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
